// File: rtl/lcd_bus_capture.sv
// lcd_bus_capture
//   Passive listener on the Model 100 LCD controller bus. It samples the bus
//   from an external master and tracks the addressing state of the ten column
//   controllers. Each accepted data byte becomes one framebuffer write into the
//   240x64 buffer that the lcd block scans out.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-low reset
//   data_pin    bus data byte (asynchronous to clk)
//   cs_pin      controller selects, bit n = controller n (active-high)
//   di_pin      1 = data, 0 = instruction
//   rw_pin      1 = read, 0 = write
//   enable_pin  bus strobe; a transfer completes on its falling edge
//   reset_pin   bus-side controller reset (active-high)
//   fb_we       one-cycle framebuffer write strobe
//   fb_x        framebuffer column of the write
//   fb_page     8-pixel row group of the write
//   fb_data     pixel byte, bit 0 = top pixel of the page
//   display_on  per-controller display-on flags
//   err_count   saturating count of dropped transfers
module lcd_bus_capture #(
    parameter int COLS          = 50,
    parameter int CHIPS_PER_ROW = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_pin,
    input  logic [9:0] cs_pin,
    input  logic       di_pin,
    input  logic       rw_pin,
    input  logic       enable_pin,
    input  logic       reset_pin,
    output logic       fb_we,
    output logic [7:0] fb_x,
    output logic [2:0] fb_page,
    output logic [7:0] fb_data,
    output logic [9:0] display_on,
    output logic [7:0] err_count
);

    localparam logic [5:0] COL_LAST  = 6'(COLS - 1);
    localparam logic [3:0] ROW_CHIPS = 4'(CHIPS_PER_ROW);

    // ------------------------------------------------------------------
    // Input synchronizers. The bus fields travel as one vector
    // {rw, di, cs, data}; bus_p is the synchronized sample one cycle older,
    // which is the copy taken while E was still high when the fall shows up.
    // ------------------------------------------------------------------
    logic [19:0] bus_s1, bus_s2, bus_p;
    logic        e_s1, e_s2, e_p;
    logic        rp_s1, rp_s2;

    // NOTE: sequential state always uses non-blocking assignment, so each
    // flop in a chain samples the value its neighbour held before the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus_s1 <= '0;
            bus_s2 <= '0;
            bus_p  <= '0;
            e_s1   <= 1'b0;
            e_s2   <= 1'b0;
            e_p    <= 1'b0;
            rp_s1  <= 1'b0;
            rp_s2  <= 1'b0;
        end else begin
            bus_s1 <= {rw_pin, di_pin, cs_pin, data_pin};
            bus_s2 <= bus_s1;
            bus_p  <= bus_s2;
            e_s1   <= enable_pin;
            e_s2   <= e_s1;
            e_p    <= e_s2;
            rp_s1  <= reset_pin;
            rp_s2  <= rp_s1;
        end
    end

    logic [7:0] bus_data;
    logic [9:0] bus_cs;
    logic       bus_di;
    logic       bus_rw;
    logic       fall;

    assign bus_data = bus_p[7:0];
    assign bus_cs   = bus_p[17:8];
    assign bus_di   = bus_p[18];
    assign bus_rw   = bus_p[19];
    assign fall     = e_p & ~e_s2;

    // ------------------------------------------------------------------
    // Controller state (ten controllers, packed per field)
    // ------------------------------------------------------------------
    logic [9:0][1:0] page_q;
    logic [9:0][5:0] col_q;
    logic [9:0]      up_q;
    logic [9:0]      on_q;
    logic [9:0][1:0] start_q;

    // Start line is kept as controller state only; nothing in this block
    // consumes it yet.
    logic unused_start;
    assign unused_start = ^start_q;

    // Select decode for the transfer being latched.
    logic [3:0] chip_idx;
    logic       cs_one;

    // NOTE: every always_comb output gets a default before any branch, so
    // no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        chip_idx = '0;
        for (int i = 0; i < 10; i++) begin
            if (bus_cs[i]) chip_idx = 4'(i);
        end
        cs_one = (bus_cs != '0) && ((bus_cs & (bus_cs - 10'd1)) == '0);
    end

    // ------------------------------------------------------------------
    // Stage 1: latch the transfer and look up the selected chip's address.
    // Reads, empty selects and anything seen under bus reset are dropped here.
    // ------------------------------------------------------------------
    logic       s1_valid;
    logic       s1_di;
    logic [7:0] s1_data;
    logic [9:0] s1_cs;
    logic       s1_one;
    logic [3:0] s1_chip;
    logic [1:0] s1_page;
    logic [5:0] s1_col;
    logic       s1_up;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_di    <= 1'b0;
            s1_data  <= '0;
            s1_cs    <= '0;
            s1_one   <= 1'b0;
            s1_chip  <= '0;
            s1_page  <= '0;
            s1_col   <= '0;
            s1_up    <= 1'b0;
        end else begin
            s1_valid <= fall & ~rp_s2 & ~bus_rw & (|bus_cs);
            if (fall) begin
                s1_di   <= bus_di;
                s1_data <= bus_data;
                s1_cs   <= bus_cs;
                s1_one  <= cs_one;
                s1_chip <= chip_idx;
                s1_page <= page_q[chip_idx];
                s1_col  <= col_q[chip_idx];
                s1_up   <= up_q[chip_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 decode
    // ------------------------------------------------------------------
    logic       ins_on, ins_up, ins_start, ins_addr, ins_ok;
    logic       do_write, err_inc;
    logic       bottom;
    logic [3:0] row_chip;
    logic [7:0] x_base;
    logic [5:0] col_next;

    always_comb begin
        ins_on    = (s1_data[7:1] == 7'h1C);   // 0x38 / 0x39
        ins_up    = (s1_data[7:1] == 7'h1D);   // 0x3A / 0x3B
        ins_start = (s1_data[5:0] == 6'h3E);
        ins_addr  = (s1_data[5:0] <= COL_LAST);
        ins_ok    = ins_on | ins_up | ins_start | ins_addr;

        do_write  = s1_valid & s1_di & s1_one;
        err_inc   = s1_valid & (s1_di ? ~s1_one : ~ins_ok);

        bottom    = (s1_chip >= ROW_CHIPS);
        row_chip  = bottom ? (s1_chip - ROW_CHIPS) : s1_chip;
        x_base    = 8'(32'(row_chip) * COLS);

        // Column auto-step wraps inside 0..COLS-1 in either direction.
        if (s1_up) col_next = (s1_col == COL_LAST) ? 6'd0 : s1_col + 6'd1;
        else       col_next = (s1_col == 6'd0) ? COL_LAST : s1_col - 6'd1;
    end

    // Controller state update. Bus reset overrides any decode in progress.
    // NOTE: the controller "memory" is a few dozen flops, not a RAM, so it
    // takes the asynchronous reset like the rest of the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            page_q  <= '0;
            col_q   <= '0;
            up_q    <= '1;
            on_q    <= '0;
            start_q <= '0;
        end else if (rp_s2) begin
            page_q  <= '0;
            col_q   <= '0;
            up_q    <= '1;
            on_q    <= '0;
            start_q <= '0;
        end else if (s1_valid) begin
            if (s1_di) begin
                if (s1_one) col_q[s1_chip] <= col_next;
            end else begin
                for (int i = 0; i < 10; i++) begin
                    if (s1_cs[i]) begin
                        if (ins_on) begin
                            on_q[i] <= s1_data[0];
                        end else if (ins_up) begin
                            up_q[i] <= s1_data[0];
                        end else if (ins_start) begin
                            start_q[i] <= s1_data[7:6];
                        end else if (ins_addr) begin
                            page_q[i] <= s1_data[7:6];
                            col_q[i]  <= s1_data[5:0];
                        end
                    end
                end
            end
        end
    end

    assign display_on = on_q;

    // Framebuffer write port and error counter. Address/data hold until the
    // next accepted write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_we     <= 1'b0;
            fb_x      <= '0;
            fb_page   <= '0;
            fb_data   <= '0;
            err_count <= '0;
        end else begin
            fb_we <= do_write;
            if (do_write) begin
                fb_x    <= x_base + {2'b00, s1_col};
                fb_page <= {bottom, s1_page};
                fb_data <= s1_data;
            end
            if (err_inc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_lcd_bus_capture.sv
// tb_lcd_bus_capture
//   Drives bus transfers into lcd_bus_capture and compares the framebuffer
//   port, display flags and error count against a controller model kept in
//   plain integer arrays.
module tb_lcd_bus_capture;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_pin = '0;
    logic [9:0] cs_pin = '0;
    logic       di_pin = 1'b0;
    logic       rw_pin = 1'b0;
    logic       enable_pin = 1'b0;
    logic       reset_pin = 1'b0;
    logic       fb_we;
    logic [7:0] fb_x;
    logic [2:0] fb_page;
    logic [7:0] fb_data;
    logic [9:0] display_on;
    logic [7:0] err_count;

    lcd_bus_capture dut (
        .clk        (clk),
        .reset      (reset),
        .data_pin   (data_pin),
        .cs_pin     (cs_pin),
        .di_pin     (di_pin),
        .rw_pin     (rw_pin),
        .enable_pin (enable_pin),
        .reset_pin  (reset_pin),
        .fb_we      (fb_we),
        .fb_x       (fb_x),
        .fb_page    (fb_page),
        .fb_data    (fb_data),
        .display_on (display_on),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Controller model
    int m_page[10];
    int m_col[10];
    int m_up[10];
    int m_on[10];
    int m_start[10];
    int m_err;
    int last_x, last_pg, last_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_ctrl_reset();
        for (int i = 0; i < 10; i++) begin
            m_page[i] = 0; m_col[i] = 0; m_up[i] = 1; m_on[i] = 0; m_start[i] = 0;
        end
    endtask

    function automatic logic [9:0] model_display();
        logic [9:0] v;
        for (int i = 0; i < 10; i++) v[i] = (m_on[i] != 0);
        return v;
    endfunction

    task automatic model_err();
        if (m_err < 255) m_err++;
    endtask

    // One complete bus transfer plus observation of the write window.
    task automatic xfer(input logic [9:0] cs, input logic di, input logic rw,
                        input logic [7:0] d, input string tag);
        bit exp_we;
        int exp_x, exp_pg, n, c, kind, we_cnt, we_cyc;
        logic [7:0] cap_x, cap_d;
        logic [2:0] cap_pg;

        // Expected behaviour from the bus rules.
        exp_we = 0; exp_x = 0; exp_pg = 0; c = 0;
        n = $countones(cs);
        if (!rw && n > 0) begin
            if (di) begin
                if (n == 1) begin
                    for (int i = 0; i < 10; i++) if (cs[i]) c = i;
                    exp_we = 1;
                    exp_x  = (c % 5) * 50 + m_col[c];
                    exp_pg = m_page[c] + ((c >= 5) ? 4 : 0);
                    m_col[c] = (m_up[c] != 0) ? (m_col[c] + 1) % 50 : (m_col[c] + 49) % 50;
                end else begin
                    model_err();
                end
            end else begin
                if (d == 8'h38 || d == 8'h39)      kind = 1;
                else if (d == 8'h3A || d == 8'h3B) kind = 2;
                else if (d % 64 == 62)             kind = 3;
                else if (d % 64 < 50)              kind = 4;
                else                               kind = 0;
                if (kind == 0) model_err();
                for (int i = 0; i < 10; i++) begin
                    if (cs[i]) begin
                        case (kind)
                            1: m_on[i] = d % 2;
                            2: m_up[i] = d % 2;
                            3: m_start[i] = d / 64;
                            4: begin m_page[i] = d / 64; m_col[i] = d % 64; end
                            default: ;
                        endcase
                    end
                end
            end
        end

        // Drive the transfer: E high long enough for the synced fields to settle.
        cs_pin = cs; di_pin = di; rw_pin = rw; data_pin = d; enable_pin = 1'b1;
        repeat (5) @(posedge clk);
        #1 enable_pin = 1'b0;
        we_cnt = 0; we_cyc = 0; cap_x = '0; cap_pg = '0; cap_d = '0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            #1;
            if (fb_we === 1'b1) begin
                we_cnt++;
                if (we_cnt == 1) begin
                    we_cyc = k; cap_x = fb_x; cap_pg = fb_page; cap_d = fb_data;
                end
            end
        end

        check({tag, " we_pulses"}, 32'(we_cnt), 32'(exp_we));
        if (exp_we) begin
            check({tag, " we_latency"}, 32'(we_cyc), 32'd4);
            check({tag, " fb_x"}, 32'(cap_x), 32'(exp_x));
            check({tag, " fb_page"}, 32'(cap_pg), 32'(exp_pg));
            check({tag, " fb_data"}, 32'(cap_d), 32'(d));
            last_x = exp_x; last_pg = exp_pg; last_d = d;
        end
        check({tag, " hold_x"}, 32'(fb_x), 32'(last_x));
        check({tag, " hold_page"}, 32'(fb_page), 32'(last_pg));
        check({tag, " hold_data"}, 32'(fb_data), 32'(last_d));
        check({tag, " display_on"}, 32'(display_on), 32'(model_display()));
        check({tag, " err_count"}, 32'(err_count), 32'(m_err));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " fb_we"}, 32'(fb_we), 32'd0);
        check({tag, " fb_x"}, 32'(fb_x), 32'd0);
        check({tag, " fb_page"}, 32'(fb_page), 32'd0);
        check({tag, " fb_data"}, 32'(fb_data), 32'd0);
        check({tag, " display_on"}, 32'(display_on), 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        logic [9:0] cs;
        logic [7:0] d;
        logic       di, rw;
        int         we_seen;

        model_ctrl_reset();
        m_err = 0; last_x = 0; last_pg = 0; last_d = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Chip 2: address col 5, then two data bytes
        xfer(10'h004, 1'b0, 1'b0, 8'h05, "c2_ins");
        xfer(10'h004, 1'b1, 1'b0, 8'hA5, "c2_d0");
        xfer(10'h004, 1'b1, 1'b0, 8'h5A, "c2_d1");

        // Chip 7: page 3 col 49, wrap to col 0
        xfer(10'h080, 1'b0, 1'b0, 8'hF1, "c7_ins");
        xfer(10'h080, 1'b1, 1'b0, 8'h11, "c7_d0");
        xfer(10'h080, 1'b1, 1'b0, 8'h22, "c7_d1");

        // Chip 0: count down, wrap 0 -> 49
        xfer(10'h001, 1'b0, 1'b0, 8'h3A, "c0_down");
        xfer(10'h001, 1'b0, 1'b0, 8'h00, "c0_addr");
        xfer(10'h001, 1'b1, 1'b0, 8'h01, "c0_d0");
        xfer(10'h001, 1'b1, 1'b0, 8'h02, "c0_d1");

        // Broadcast display on, then an illegal multi-select data write
        xfer(10'h3FF, 1'b0, 1'b0, 8'h39, "all_on");
        xfer(10'h003, 1'b1, 1'b0, 8'h55, "multi_cs");

        // Read cycle must not touch state
        xfer(10'h001, 1'b0, 1'b0, 8'h00, "c0_readdr");
        xfer(10'h001, 1'b1, 1'b1, 8'h99, "c0_read");
        xfer(10'h001, 1'b1, 1'b0, 8'h66, "c0_after_rd");

        // Empty select and undefined instruction
        xfer(10'h000, 1'b1, 1'b0, 8'h12, "cs_none");
        xfer(10'h010, 1'b0, 1'b0, 8'h3F, "bad_ins");

        // Bus-side controller reset
        enable_pin = 1'b0;
        reset_pin = 1'b1;
        repeat (6) @(posedge clk);
        #1 reset_pin = 1'b0;
        repeat (4) @(posedge clk);
        #1 model_ctrl_reset();
        xfer(10'h200, 1'b1, 1'b0, 8'hC3, "after_rstpin");

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 9))
                0:       cs = 10'h000;
                1, 2:    cs = 10'($urandom);
                default: cs = 10'(1) << $urandom_range(0, 9);
            endcase
            di = 1'($urandom_range(0, 1));
            rw = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 5))
                0:       d = 8'h38 + 8'($urandom_range(0, 3));
                1:       d = {2'($urandom_range(0, 3)), 6'h3E};
                default: d = 8'($urandom);
            endcase
            xfer(cs, di, rw, d, $sformatf("rnd%0d", t));
        end

        // Reset between E falling and the write strobe
        cs_pin = 10'h001; di_pin = 1'b1; rw_pin = 1'b0; data_pin = 8'h77;
        enable_pin = 1'b1;
        repeat (5) @(posedge clk);
        #1 enable_pin = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        we_seen = 0;
        repeat (3) begin
            @(posedge clk);
            #1 if (fb_we !== 1'b0) we_seen++;
        end
        reset = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1 if (fb_we !== 1'b0) we_seen++;
        end
        check("midxfer_rst no_we", 32'(we_seen), 32'd0);
        check_all_zero("midxfer_rst");
        model_ctrl_reset();
        m_err = 0; last_x = 0; last_pg = 0; last_d = 0;
        xfer(10'h001, 1'b1, 1'b0, 8'h3C, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
